banco_registros_param: RTL and testbench

Parametrised successor to the 32x32 processor register bank. It provides two asynchronous read ports and one synchronous write port. Reads have write-through bypass, register 0 can be hardwired to zero, and a sequential clear engine zeroes the array after reset or on command instead of preloading it from a file. It sits in the decode stage of the datapath, between instruction decode and the ALU operand muxes.

---
 rtl/banco_registros_param.sv | 123 ++++++++++++
 tb/tb_banco_registros_param.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/banco_registros_param.sv
// Parametrised register bank: two combinational read ports with write-through
// bypass, one synchronous write port, optional hardwired r0 and a sequential clear engine.
module banco_registros_param #(
    parameter int ANCHO   = 32,
    parameter int PROF    = 32,
    parameter int DIR     = 5,
    parameter int R0_CERO = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [DIR-1:0]   dirlec1,
    input  logic [DIR-1:0]   dirlec2,
    output logic [ANCHO-1:0] datolec1,
    output logic [ANCHO-1:0] datolec2,
    input  logic [DIR-1:0]   diresc,
    input  logic [ANCHO-1:0] datoesc,
    input  logic             enesc,
    input  logic             limpiar,
    output logic             ocupado,
    output logic [DIR-1:0]   cont_limpia
);

    typedef enum logic {
        LIMPIA = 1'b0,
        LISTO  = 1'b1
    } estado_t;

    localparam logic [DIR-1:0] ULTIMO = DIR'(PROF - 1);

    estado_t          estado_q, estado_d;
    logic [DIR-1:0]   cont_q, cont_d;
    logic [ANCHO-1:0] brr [PROF];

    logic             arr_we;
    logic [DIR-1:0]   arr_dir;
    logic [ANCHO-1:0] arr_dato;
    logic             esc_legal;
    logic [DIR-1:0]   dir_lec [2];

    // An address is usable if it exists and is not the hardwired r0.
    function automatic logic dir_valida(input logic [DIR-1:0] a);
        return (32'(a) < 32'(PROF)) && !((R0_CERO != 0) && (a == '0));
    endfunction

    // Clear has priority over a write in the same cycle.
    assign esc_legal = enesc && (estado_q == LISTO) && !limpiar && dir_valida(diresc);

    always_comb begin
        estado_d = estado_q;
        cont_d   = cont_q;
        arr_we   = 1'b0;
        arr_dir  = diresc;
        arr_dato = datoesc;
        case (estado_q)
            LIMPIA: begin
                arr_we   = 1'b1;
                arr_dir  = cont_q;
                arr_dato = '0;
                if (cont_q == ULTIMO) begin
                    estado_d = LISTO;
                    cont_d   = '0;
                end else begin
                    cont_d = cont_q + DIR'(1);
                end
            end
            LISTO: begin
                if (limpiar) begin
                    estado_d = LIMPIA;
                    cont_d   = '0;
                end else if (esc_legal) begin
                    arr_we = 1'b1;
                end
            end
            default: begin
                estado_d = LIMPIA;
                cont_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            estado_q <= LIMPIA;
            cont_q   <= '0;
        end else begin
            estado_q <= estado_d;
            cont_q   <= cont_d;
        end
    end

    // Storage has no reset; the clear engine initialises it after reset.
    always_ff @(posedge clk) begin
        if (rst_n && arr_we) begin
            brr[arr_dir] <= arr_dato;
        end
    end

    assign dir_lec[0] = dirlec1;
    assign dir_lec[1] = dirlec2;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_lec
            logic [ANCHO-1:0] dato;
            always_comb begin
                dato = '0;
                if ((estado_q == LISTO) && dir_valida(dir_lec[gi])) begin
                    if (esc_legal && (diresc == dir_lec[gi])) begin
                        dato = datoesc;
                    end else begin
                        dato = brr[dir_lec[gi]];
                    end
                end
            end
        end
    endgenerate

    assign datolec1    = g_lec[0].dato;
    assign datolec2    = g_lec[1].dato;
    assign ocupado     = (estado_q == LIMPIA);
    assign cont_limpia = cont_q;

endmodule

// File: tb/tb_banco_registros_param.sv
// Bench for banco_registros_param: a PROF=32/r0-hardwired instance and a PROF=20/plain-r0
// instance share the same stimulus and are checked against an array-based reference model.
module tb_banco_registros_param;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  dirlec1, dirlec2, diresc;
    logic [31:0] datoesc;
    logic        enesc, limpiar;

    logic [31:0] datolec1_a, datolec2_a, datolec1_b, datolec2_b;
    logic        ocupado_a, ocupado_b;
    logic [4:0]  cont_limpia_a, cont_limpia_b;

    always #5 clk = ~clk;

    banco_registros_param #(.ANCHO(32), .PROF(32), .DIR(5), .R0_CERO(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .dirlec1(dirlec1), .dirlec2(dirlec2),
        .datolec1(datolec1_a), .datolec2(datolec2_a), .diresc(diresc),
        .datoesc(datoesc), .enesc(enesc), .limpiar(limpiar),
        .ocupado(ocupado_a), .cont_limpia(cont_limpia_a)
    );

    banco_registros_param #(.ANCHO(32), .PROF(20), .DIR(5), .R0_CERO(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .dirlec1(dirlec1), .dirlec2(dirlec2),
        .datolec1(datolec1_b), .datolec2(datolec2_b), .diresc(diresc),
        .datoesc(datoesc), .enesc(enesc), .limpiar(limpiar),
        .ocupado(ocupado_b), .cont_limpia(cont_limpia_b)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: contents per instance plus remaining clear cycles.
    logic [31:0] mem    [2][32];
    int          busy   [2];
    int          prof_m [2] = '{32, 20};
    bit          r0_m   [2] = '{1'b1, 1'b0};

    function automatic bit legal(int k);
        return (busy[k] == 0) && enesc && !limpiar && (int'(diresc) < prof_m[k])
               && !(r0_m[k] && (diresc == 5'd0));
    endfunction

    function automatic logic [31:0] exp_read(int k, logic [4:0] a);
        if (busy[k] > 0) return 32'd0;
        if (r0_m[k] && (a == 5'd0)) return 32'd0;
        if (int'(a) >= prof_m[k]) return 32'd0;
        if (legal(k) && (diresc == a)) return datoesc;
        return mem[k][a];
    endfunction

    function automatic int exp_cont(int k);
        return (busy[k] > 0) ? (prof_m[k] - busy[k]) : 0;
    endfunction

    function automatic logic [31:0] obs1(int k);
        return (k == 0) ? datolec1_a : datolec1_b;
    endfunction

    function automatic logic [31:0] obs2(int k);
        return (k == 0) ? datolec2_a : datolec2_b;
    endfunction

    function automatic logic obs_ocup(int k);
        return (k == 0) ? ocupado_a : ocupado_b;
    endfunction

    function automatic logic [4:0] obs_cont(int k);
        return (k == 0) ? cont_limpia_a : cont_limpia_b;
    endfunction

    // Advance the model by one clock edge using the current inputs, then advance the DUT.
    task automatic tick();
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                busy[k] = prof_m[k];
                for (int i = 0; i < 32; i++) mem[k][i] = 32'd0;
            end else if (busy[k] > 0) begin
                busy[k] = busy[k] - 1;
            end else if (limpiar) begin
                busy[k] = prof_m[k];
                for (int i = 0; i < 32; i++) mem[k][i] = 32'd0;
            end else if (legal(k)) begin
                mem[k][diresc] = datoesc;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        int cnt [2];
        cnt = '{0, 0};
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 40; c++) begin
            #1;
            for (int k = 0; k < 2; k++) begin
                if (obs_ocup(k) === 1'b1) cnt[k]++;
                n_tests++;
                if (obs_cont(k) !== 5'(exp_cont(k))) begin
                    n_fail++;
                    $display("FAIL reset_cont inst%0d cycle=%0d got=%0d exp=%0d", k, c, obs_cont(k), exp_cont(k));
                end
            end
            tick();
        end
        for (int k = 0; k < 2; k++) begin
            n_tests++;
            if (cnt[k] != prof_m[k]) begin
                n_fail++;
                $display("FAIL reset_busy_len inst%0d got=%0d exp=%0d", k, cnt[k], prof_m[k]);
            end
        end
        for (int a = 0; a < 32; a++) begin
            dirlec1 = 5'(a);
            dirlec2 = 5'(31 - a);
            #1;
            for (int k = 0; k < 2; k++) begin
                n_tests++;
                if (obs1(k) !== 32'd0 || obs2(k) !== 32'd0) begin
                    n_fail++;
                    $display("FAIL reset_zero inst%0d addr=%0d got=%h/%h exp=0", k, a, obs1(k), obs2(k));
                end
            end
            tick();
        end
    endtask

    task automatic test_write_read();
        dirlec1 = 5'd5; dirlec2 = 5'd6;
        diresc  = 5'd5; datoesc = 32'hDEADBEEF; enesc = 1'b1;
        for (int ph = 0; ph < 2; ph++) begin
            #1;
            for (int k = 0; k < 2; k++) begin
                n_tests++;
                if (obs1(k) !== 32'hDEADBEEF) begin
                    n_fail++;
                    $display("FAIL wr_rd_port1 inst%0d phase=%0d got=%h exp=deadbeef", k, ph, obs1(k));
                end
                n_tests++;
                if (obs2(k) !== 32'd0) begin
                    n_fail++;
                    $display("FAIL wr_rd_port2 inst%0d phase=%0d got=%h exp=0", k, ph, obs2(k));
                end
            end
            tick();
            enesc = 1'b0; datoesc = 32'd0;
        end
    endtask

    task automatic test_r0();
        logic [31:0] expv [2];
        expv = '{32'd0, 32'h12345678};
        dirlec1 = 5'd0; dirlec2 = 5'd0;
        diresc  = 5'd0; datoesc = 32'h12345678; enesc = 1'b1;
        for (int ph = 0; ph < 2; ph++) begin
            #1;
            for (int k = 0; k < 2; k++) begin
                n_tests++;
                if (obs1(k) !== expv[k] || obs2(k) !== expv[k]) begin
                    n_fail++;
                    $display("FAIL r0 inst%0d phase=%0d got=%h/%h exp=%h", k, ph, obs1(k), obs2(k), expv[k]);
                end
            end
            tick();
            enesc = 1'b0; datoesc = 32'd0;
        end
    endtask

    task automatic test_clear_cmd();
        int cnt [2];
        cnt = '{0, 0};
        for (int a = 1; a < 32; a++) begin
            enesc = 1'b1; diresc = 5'(a); datoesc = 32'(a);
            tick();
        end
        limpiar = 1'b1; enesc = 1'b1; diresc = 5'd3; datoesc = 32'hAA; dirlec1 = 5'd3;
        #1;
        for (int k = 0; k < 2; k++) begin
            n_tests++;
            if (obs1(k) !== 32'd3) begin
                n_fail++;
                $display("FAIL clear_no_bypass inst%0d got=%h exp=3", k, obs1(k));
            end
        end
        tick();
        limpiar = 1'b0;
        diresc = 5'd7; datoesc = 32'h55; dirlec1 = 5'd7; dirlec2 = 5'd3;
        for (int c = 0; c < 40; c++) begin
            enesc = (c < 5);
            #1;
            for (int k = 0; k < 2; k++) begin
                if (obs_ocup(k) === 1'b1) cnt[k]++;
                n_tests++;
                if (obs1(k) !== exp_read(k, dirlec1)) begin
                    n_fail++;
                    $display("FAIL busy_read inst%0d cycle=%0d got=%h exp=%h", k, c, obs1(k), exp_read(k, dirlec1));
                end
            end
            tick();
        end
        enesc = 1'b0;
        for (int k = 0; k < 2; k++) begin
            n_tests++;
            if (cnt[k] != prof_m[k]) begin
                n_fail++;
                $display("FAIL clear_busy_len inst%0d got=%0d exp=%0d", k, cnt[k], prof_m[k]);
            end
        end
        for (int a = 0; a < 32; a++) begin
            dirlec1 = 5'(a); dirlec2 = 5'(a);
            #1;
            for (int k = 0; k < 2; k++) begin
                n_tests++;
                if (obs1(k) !== 32'd0 || obs2(k) !== 32'd0) begin
                    n_fail++;
                    $display("FAIL clear_zero inst%0d addr=%0d got=%h/%h exp=0", k, a, obs1(k), obs2(k));
                end
            end
            tick();
        end
    endtask

    task automatic test_random(int n);
        int guard;
        for (int i = 0; i < n; i++) begin
            diresc  = 5'($urandom_range(0, 31));
            datoesc = $urandom;
            enesc   = 1'($urandom_range(0, 1));
            limpiar = ($urandom_range(0, 59) == 0);
            dirlec1 = ($urandom_range(0, 3) == 0) ? diresc : 5'($urandom_range(0, 31));
            dirlec2 = ($urandom_range(0, 3) == 0) ? dirlec1 : 5'($urandom_range(0, 31));
            #1;
            for (int k = 0; k < 2; k++) begin
                n_tests++;
                if (obs1(k) !== exp_read(k, dirlec1) || obs2(k) !== exp_read(k, dirlec2)) begin
                    n_fail++;
                    $display("FAIL rand_read inst%0d i=%0d a1=%0d a2=%0d got=%h/%h exp=%h/%h", k, i,
                             dirlec1, dirlec2, obs1(k), obs2(k), exp_read(k, dirlec1), exp_read(k, dirlec2));
                end
                n_tests++;
                if (obs_ocup(k) !== (busy[k] > 0) || obs_cont(k) !== 5'(exp_cont(k))) begin
                    n_fail++;
                    $display("FAIL rand_ctrl inst%0d i=%0d ocupado=%b cont=%0d exp=%b/%0d", k, i,
                             obs_ocup(k), obs_cont(k), (busy[k] > 0), exp_cont(k));
                end
            end
            tick();
        end
        enesc = 1'b0; limpiar = 1'b0;
        guard = 0;
        while ((busy[0] > 0 || busy[1] > 0) && guard < 64) begin
            tick();
            guard++;
        end
    endtask

    task automatic test_mid_reset();
        int cnt [2];
        int guard;
        cnt = '{0, 0};
        limpiar = 1'b1;
        tick();
        limpiar = 1'b0;
        guard = 0;
        #1;
        while (cont_limpia_b !== 5'd10 && guard < 40) begin
            tick();
            #1;
            guard++;
        end
        n_tests++;
        if (guard >= 40 || exp_cont(1) != 10) begin
            n_fail++;
            $display("FAIL mid_reset_reach10 got=%0d exp=10 model=%0d", cont_limpia_b, exp_cont(1));
        end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 40; c++) begin
            #1;
            for (int k = 0; k < 2; k++) begin
                if (obs_ocup(k) === 1'b1) cnt[k]++;
                if (c == 0) begin
                    n_tests++;
                    if (obs_cont(k) !== 5'd0) begin
                        n_fail++;
                        $display("FAIL mid_reset_restart inst%0d got=%0d exp=0", k, obs_cont(k));
                    end
                end
            end
            tick();
        end
        for (int k = 0; k < 2; k++) begin
            n_tests++;
            if (cnt[k] != prof_m[k]) begin
                n_fail++;
                $display("FAIL mid_reset_busy_len inst%0d got=%0d exp=%0d", k, cnt[k], prof_m[k]);
            end
        end
        enesc = 1'b1; diresc = 5'd25; datoesc = 32'hCAFEF00D; dirlec1 = 5'd25; dirlec2 = 5'd25;
        for (int ph = 0; ph < 2; ph++) begin
            #1;
            n_tests++;
            if (datolec1_b !== 32'd0 || datolec2_b !== 32'd0) begin
                n_fail++;
                $display("FAIL oor_b phase=%0d got=%h/%h exp=0", ph, datolec1_b, datolec2_b);
            end
            n_tests++;
            if (datolec1_a !== 32'hCAFEF00D || datolec2_a !== 32'hCAFEF00D) begin
                n_fail++;
                $display("FAIL r25_a phase=%0d got=%h/%h exp=cafef00d", ph, datolec1_a, datolec2_a);
            end
            tick();
            enesc = 1'b0; datoesc = 32'd0;
        end
    endtask

    initial begin
        rst_n = 1'b0; enesc = 1'b0; limpiar = 1'b0;
        dirlec1 = '0; dirlec2 = '0; diresc = '0; datoesc = '0;
        for (int k = 0; k < 2; k++) begin
            busy[k] = prof_m[k];
            for (int i = 0; i < 32; i++) mem[k][i] = 32'd0;
        end
        @(negedge clk);
        test_reset();
        test_write_read();
        test_r0();
        test_clear_cmd();
        test_random(400);
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
